// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: shadowed hex value, per-digit dp,
// leading-zero blanking, anti-ghosting guard at slot start and digit blinking.
module seg_scan_ctrl #(
    parameter int DIGIT_CNT = 8,
    parameter int CLK_DIV   = 100000,
    parameter int GUARD     = 1,
    parameter int BLINK_DIV = 125
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4*DIGIT_CNT-1:0] number,
    input  logic [DIGIT_CNT-1:0]   dp,
    input  logic                   load,
    input  logic                   blank_lz,
    input  logic [DIGIT_CNT-1:0]   blink_mask,
    output logic [7:0]             seg_o,
    output logic [DIGIT_CNT-1:0]   sel_o,
    output logic                   frame_o
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (DIGIT_CNT > 1) ? $clog2(DIGIT_CNT) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GUARD_V   = PW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGIT_CNT - 1);
    localparam logic [FW-1:0] FC_MAX    = FW'(BLINK_DIV - 1);

    logic [PW-1:0]          presc;
    logic [IW-1:0]          idx;
    logic [FW-1:0]          frame_cnt;
    logic                   phase;
    logic [4*DIGIT_CNT-1:0] shadow_num;
    logic [DIGIT_CNT-1:0]   shadow_dp;

    logic                   tick;
    logic                   frame_wrap;
    logic [DIGIT_CNT-1:0]   lz_blank;
    logic                   all_zero;
    logic [3:0]             nibble;
    logic [DIGIT_CNT-1:0]   sel_next;
    logic [7:0]             seg_next;

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        case (h)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    assign tick       = (presc == PRESC_MAX);
    assign frame_wrap = tick && (idx == IDX_MAX);

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int i = DIGIT_CNT - 1; i >= 1; i--) begin
            all_zero    = all_zero & (shadow_num[i*4 +: 4] == 4'h0);
            lz_blank[i] = all_zero;
        end
    end

    always_comb begin
        nibble   = shadow_num[{idx, 2'b00} +: 4];
        sel_next = '0;
        if (presc >= GUARD_V) begin
            sel_next[idx] = 1'b1;
        end
        // Blink wins over everything, including the decimal point.
        if (phase && blink_mask[idx]) begin
            seg_next = 8'h00;
        end else if (blank_lz && lz_blank[idx]) begin
            seg_next = {shadow_dp[idx], 7'h00};
        end else begin
            seg_next = {shadow_dp[idx], hex_decode(nibble)};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc      <= '0;
            idx        <= '0;
            frame_cnt  <= '0;
            phase      <= 1'b0;
            shadow_num <= '0;
            shadow_dp  <= '0;
            sel_o      <= '0;
            seg_o      <= 8'h00;
            frame_o    <= 1'b0;
        end else begin
            if (load) begin
                shadow_num <= number;
                shadow_dp  <= dp;
            end
            presc   <= tick ? '0 : presc + PW'(1);
            frame_o <= frame_wrap;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
            end
            if (frame_wrap) begin
                if (frame_cnt == FC_MAX) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
            sel_o <= sel_next;
            seg_o <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGIT_CNT=4, CLK_DIV=4, GUARD=1, BLINK_DIV=2:
// a table of single-digit vectors plus hand-written scan, blink, reset and load sequences.
module tb_seg_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] number;
    logic [3:0]  dp;
    logic        load;
    logic        blank_lz;
    logic [3:0]  blink_mask;
    logic [7:0]  seg_o;
    logic [3:0]  sel_o;
    logic        frame_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [15:0] num;
        logic [3:0]  dpv;
        logic        blz;
        int          digit;
        logic [7:0]  exp_seg;
    } vec_t;

    vec_t       tbl[20];
    logic [7:0] seg1234[4];

    seg_scan_ctrl #(
        .DIGIT_CNT(4),
        .CLK_DIV  (4),
        .GUARD    (1),
        .BLINK_DIV(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .number    (number),
        .dp        (dp),
        .load      (load),
        .blank_lz  (blank_lz),
        .blink_mask(blink_mask),
        .seg_o     (seg_o),
        .sel_o     (sel_o),
        .frame_o   (frame_o)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset for one edge, then load on the first edge after release.
    task automatic reset_load(input logic [15:0] num, input logic [3:0] dpv);
        number = num;
        dp     = dpv;
        reset  = 1'b1;
        load   = 1'b0;
        step();
        reset  = 1'b0;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic wait_sel(input logic [3:0] target);
        int n = 0;
        while (sel_o !== target && n < 40) begin
            step();
            n++;
        end
        if (sel_o !== target) begin
            checks++;
            errors++;
            $display("FAIL wait_sel: sel_o=%b never reached %b", sel_o, target);
        end
    endtask

    initial begin
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
        int         ix;
        int         fr;

        reset      = 1'b1;
        load       = 1'b0;
        number     = 16'h0000;
        dp         = 4'h0;
        blank_lz   = 1'b0;
        blink_mask = 4'h0;
        seg1234[0] = 8'h66;
        seg1234[1] = 8'h4F;
        seg1234[2] = 8'h5B;
        seg1234[3] = 8'h06;

        tbl[0]  = '{16'h1234, 4'h0, 1'b0, 0, 8'h66};
        tbl[1]  = '{16'h1234, 4'h0, 1'b0, 1, 8'h4F};
        tbl[2]  = '{16'h1234, 4'h0, 1'b0, 2, 8'h5B};
        tbl[3]  = '{16'h1234, 4'h0, 1'b0, 3, 8'h06};
        tbl[4]  = '{16'h0070, 4'h0, 1'b1, 3, 8'h00};
        tbl[5]  = '{16'h0070, 4'h0, 1'b1, 2, 8'h00};
        tbl[6]  = '{16'h0070, 4'h0, 1'b1, 1, 8'h07};
        tbl[7]  = '{16'h0070, 4'h0, 1'b1, 0, 8'h3F};
        tbl[8]  = '{16'h0070, 4'h0, 1'b0, 3, 8'h3F};
        tbl[9]  = '{16'h0070, 4'h0, 1'b0, 2, 8'h3F};
        tbl[10] = '{16'h0000, 4'h8, 1'b1, 3, 8'h80};
        tbl[11] = '{16'h0000, 4'h8, 1'b1, 0, 8'h3F};
        tbl[12] = '{16'h0000, 4'h8, 1'b1, 1, 8'h00};
        tbl[13] = '{16'hABCD, 4'h5, 1'b0, 0, 8'hDE};
        tbl[14] = '{16'hABCD, 4'h5, 1'b0, 1, 8'h39};
        tbl[15] = '{16'hABCD, 4'h5, 1'b0, 2, 8'hFC};
        tbl[16] = '{16'hABCD, 4'h5, 1'b0, 3, 8'h77};
        tbl[17] = '{16'hEF59, 4'h0, 1'b1, 1, 8'h6D};
        tbl[18] = '{16'h0678, 4'h0, 1'b1, 3, 8'h00};
        tbl[19] = '{16'h0678, 4'h0, 1'b1, 2, 8'h7D};

        // Reset state, then first cycles after release without any load.
        step();
        step();
        check("rst_sel", {4'h0, sel_o}, 8'h00);
        check("rst_seg", seg_o, 8'h00);
        check("rst_frame", {7'h0, frame_o}, 8'h00);
        number = 16'h1234;
        reset  = 1'b0;
        step();
        check("rel_guard_sel", {4'h0, sel_o}, 8'h00);
        step();
        check("rel_d0_sel", {4'h0, sel_o}, 8'h01);
        check("rel_d0_seg", seg_o, 8'h3F);

        // Table of single-digit vectors.
        for (int v = 0; v < 20; v++) begin
            blank_lz   = tbl[v].blz;
            blink_mask = 4'h0;
            reset_load(tbl[v].num, tbl[v].dpv);
            wait_sel(4'b0001 << tbl[v].digit);
            exp_q.push_back(tbl[v].exp_seg);
            check($sformatf("vec%0d_seg", v), seg_o, exp_q.pop_front());
        end

        // Full scan of 0x1234: edge n after release shows slot state from edge n-1.
        blank_lz = 1'b0;
        reset_load(16'h1234, 4'h0);
        for (int n = 2; n <= 33; n++) begin
            step();
            ix      = ((n - 1) / 4) % 4;
            exp_sel = (((n - 1) % 4) == 0) ? 4'b0000 : (4'b0001 << ix);
            check($sformatf("scan_sel_n%0d", n), {4'h0, sel_o}, {4'h0, exp_sel});
            check($sformatf("scan_frame_n%0d", n), {7'h0, frame_o}, ((n % 16) == 0) ? 8'h01 : 8'h00);
            if (exp_sel != 4'b0000) begin
                check($sformatf("scan_seg_n%0d", n), seg_o, seg1234[ix]);
            end
        end

        // Blink digit 0: lit in frames 0-1, dark in frames 2-3.
        blink_mask = 4'b0001;
        reset_load(16'h8888, 4'h0);
        for (int n = 2; n <= 58; n++) begin
            step();
            ix = ((n - 1) / 4) % 4;
            fr = (n - 1) / 16;
            if (((n - 1) % 4) != 0) begin
                exp_seg = (ix == 0 && ((fr / 2) % 2) == 1) ? 8'h00 : 8'h7F;
                check($sformatf("blink_seg_n%0d", n), seg_o, exp_seg);
            end
        end

        // Reset mid digit-2 slot in blink phase 1, with load asserted.
        check("pre_rst_sel", {4'h0, sel_o}, 8'h04);
        reset  = 1'b1;
        load   = 1'b1;
        number = 16'hFFFF;
        step();
        check("mid_rst_sel", {4'h0, sel_o}, 8'h00);
        check("mid_rst_seg", seg_o, 8'h00);
        check("mid_rst_frame", {7'h0, frame_o}, 8'h00);
        reset = 1'b0;
        load  = 1'b0;
        step();
        check("post_rst_guard", {4'h0, sel_o}, 8'h00);
        step();
        check("post_rst_sel", {4'h0, sel_o}, 8'h01);
        check("post_rst_seg", seg_o, 8'h3F);
        for (int n = 3; n <= 16; n++) begin
            step();
            if (n == 15) begin
                check("post_rst_noframe", {7'h0, frame_o}, 8'h00);
            end
        end
        check("post_rst_frame", {7'h0, frame_o}, 8'h01);

        // Number change without load, then a mid-slot load.
        blink_mask = 4'h0;
        reset_load(16'h1234, 4'h0);
        wait_sel(4'b0001);
        check("nl_seg0", seg_o, 8'h66);
        number = 16'h9999;
        step();
        check("nl_sel1", {4'h0, sel_o}, 8'h01);
        check("nl_seg1", seg_o, 8'h66);
        wait_sel(4'b0010);
        check("ml_seg0", seg_o, 8'h4F);
        load = 1'b1;
        step();
        load = 1'b0;
        check("ml_seg_edge", seg_o, 8'h4F);
        step();
        check("ml_sel_next", {4'h0, sel_o}, 8'h02);
        check("ml_seg_next", seg_o, 8'h6F);
        step();
        check("ml_guard", {4'h0, sel_o}, 8'h00);
        step();
        check("ml_sel_d2", {4'h0, sel_o}, 8'h04);
        check("ml_seg_d2", seg_o, 8'h6F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
